// File: rtl/shift_operand_stage_pkg.sv
// Shared types and helpers for the multiplier operand-preparation stage.
// Holds the skid-buffer state encoding, the operand pair, and the shift helper.
package shift_operand_pkg;

    localparam int OP_IN_W  = 16;
    localparam int OP_OUT_W = 32;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } skid_state_t;

    typedef struct packed {
        logic [OP_OUT_W-1:0] a;
        logic [OP_OUT_W-1:0] b;
    } op_pair_t;

    // Logical right shift in the raw width, then zero-extend to the delivered width.
    function automatic logic [OP_OUT_W-1:0] shift_mask(
        input logic [OP_IN_W-1:0] value,
        input int unsigned        sh
    );
        logic [OP_IN_W-1:0] shifted;
        shifted = value >> sh;
        return OP_OUT_W'(shifted);
    endfunction

endpackage

// File: rtl/shift_operand_stage_if.sv
// Operand-pair bus: upstream raw pairs in, shifted pairs out, delivered count.
// master = the side driving pairs in and accepting them out; slave = the stage.
interface shift_operand_stage_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_a;
    logic [IN_W-1:0]  in_b;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_a;
    logic [OUT_W-1:0] out_b;
    logic [CNT_W-1:0] xfer_count;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_a, out_b, xfer_count
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_a, out_b, xfer_count
    );

endinterface

// File: rtl/shift_operand_stage_skid_buffer2.sv
// Generic 2-entry valid/ready register slice with a main and a skid register.
// Ready and valid decode straight from the state flop: no comb in->out paths.
module skid_buffer2
    import shift_operand_pkg::*;
#(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    skid_state_t state_q, state_d;
    T            main_q, main_d;
    T            skid_q, skid_d;
    logic        in_hs;
    logic        out_hs;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // Next-state and register-load decode for the EMPTY/ONE/TWO occupancy FSM.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_hs && out_hs) begin
                    main_d = in_data;
                end else if (in_hs) begin
                    skid_d  = in_data;
                    state_d = TWO;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_hs) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State and payload registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Occupancy sanity and hold-under-backpressure checks.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(out_valid && !in_ready && state_q == EMPTY));
            if (out_valid && !out_ready) begin
                assert (main_d == main_q && state_d != EMPTY);
            end
        end
    end

endmodule

// File: rtl/shift_operand_stage.sv
// Operand-preparation stage: shift raw operand pairs, zero-extend, buffer
// them through a 2-entry skid slice, and count pairs delivered downstream.
module shift_operand_stage
    import shift_operand_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 1,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_operand_stage_if.slave bus
);

    if (OUT_W < IN_W) begin : g_bad_width
        $error("shift_operand_stage: OUT_W must be >= IN_W");
    end

    if (SHIFT < 0 || SHIFT >= IN_W) begin : g_bad_shift
        $error("shift_operand_stage: SHIFT must be in 0..IN_W-1");
    end

    typedef struct packed {
        logic [OUT_W-1:0] a;
        logic [OUT_W-1:0] b;
    } pair_t;

    pair_t            in_pair;
    pair_t            out_pair;
    logic             out_hs;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    if (IN_W == OP_IN_W && OUT_W == OP_OUT_W) begin : g_pkg_shift
        // Default widths use the shared helper so the multiplier side agrees.
        always_comb begin
            in_pair.a = shift_mask(bus.in_a, SHIFT);
            in_pair.b = shift_mask(bus.in_b, SHIFT);
        end
    end else begin : g_gen_shift
        // Shift in the raw width; the cast zero-extends to OUT_W.
        always_comb begin
            in_pair.a = OUT_W'(bus.in_a >> SHIFT);
            in_pair.b = OUT_W'(bus.in_b >> SHIFT);
        end
    end

    skid_buffer2 #(
        .T (pair_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_pair),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_pair)
    );

    assign bus.out_a      = out_pair.a;
    assign bus.out_b      = out_pair.b;
    assign out_hs         = bus.out_valid && bus.out_ready;
    assign bus.xfer_count = cnt_q;

    // Delivered-pair count, pinned at all-ones once saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (out_hs && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Bits shifted in from the top must always read as zero.
    always @(posedge clk) begin
        if (!rst) begin
            assert ((bus.out_a >> (IN_W - SHIFT)) == '0);
            assert ((bus.out_b >> (IN_W - SHIFT)) == '0);
        end
    end

endmodule

// File: tb/tb_shift_operand_stage.sv
// Self-checking bench for shift_operand_stage: scoreboard of expected pairs,
// one task per scenario, three builds (default, CNT_W=4, SHIFT=0).
module tb_shift_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    logic [63:0] prod;

    always #5 clk = ~clk;

    shift_operand_stage_if #(.IN_W(16), .OUT_W(32), .CNT_W(16)) m_if ();
    shift_operand_stage_if #(.IN_W(16), .OUT_W(32), .CNT_W(4))  c_if ();
    shift_operand_stage_if #(.IN_W(16), .OUT_W(32), .CNT_W(16)) z_if ();

    shift_operand_stage #(
        .IN_W(16), .OUT_W(32), .SHIFT(1), .CNT_W(16)
    ) u_main (
        .clk(clk), .rst(rst), .bus(m_if.slave)
    );

    shift_operand_stage #(
        .IN_W(16), .OUT_W(32), .SHIFT(1), .CNT_W(4)
    ) u_cnt4 (
        .clk(clk), .rst(rst), .bus(c_if.slave)
    );

    shift_operand_stage #(
        .IN_W(16), .OUT_W(32), .SHIFT(0), .CNT_W(16)
    ) u_sh0 (
        .clk(clk), .rst(rst), .bus(z_if.slave)
    );

    function automatic logic [63:0] model(
        input logic [15:0] a,
        input logic [15:0] b,
        input int          sh
    );
        logic [31:0] ea;
        logic [31:0] eb;
        ea = {16'h0000, a} >> sh;
        eb = {16'h0000, b} >> sh;
        return {ea, eb};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (m_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", m_if.out_valid);
        end
        checks++;
        if (m_if.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", m_if.in_ready);
        end
        checks++;
        if ({m_if.out_a, m_if.out_b} !== 64'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {m_if.out_a, m_if.out_b});
        end
        checks++;
        if (m_if.xfer_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_count got=%h exp=0", m_if.xfer_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_pair();
        @(negedge clk);
        m_if.in_a = 16'hfff0;
        m_if.in_b = 16'h00e4;
        m_if.in_valid = 1'b1;
        m_if.out_ready = 1'b1;
        checks++;
        if (m_if.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL first_in_ready got=%b exp=1", m_if.in_ready);
        end
        sb.push_back(model(16'hfff0, 16'h00e4, 1));
        @(negedge clk);
        m_if.in_valid = 1'b0;
        checks++;
        if (m_if.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_out_valid got=%b exp=1", m_if.out_valid);
        end
        prod = m_if.out_a * m_if.out_b;
        checks++;
        if (prod !== 64'h0038fc70) begin
            failures++;
            $display("FAIL first_product got=%h exp=0038fc70", prod);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL first_data got=%h exp=<none>", {m_if.out_a, m_if.out_b});
        end else begin
            exp_v = sb.pop_front();
            if ({m_if.out_a, m_if.out_b} !== exp_v) begin
                failures++;
                $display("FAIL first_data got=%h exp=%h", {m_if.out_a, m_if.out_b}, exp_v);
            end
        end
        @(negedge clk);
        checks++;
        if (m_if.xfer_count !== 16'd1) begin
            failures++;
            $display("FAIL first_count got=%0d exp=1", m_if.xfer_count);
        end
        checks++;
        if (m_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_drained got=%b exp=0", m_if.out_valid);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        m_if.out_ready = 1'b0;
        m_if.in_valid = 1'b1;
        m_if.in_a = 16'h0002;
        m_if.in_b = 16'h0004;
        sb.push_back(model(16'h0002, 16'h0004, 1));
        @(negedge clk);
        m_if.in_a = 16'h0010;
        m_if.in_b = 16'h0020;
        checks++;
        if (m_if.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_second_ready got=%b exp=1", m_if.in_ready);
        end
        sb.push_back(model(16'h0010, 16'h0020, 1));
        @(negedge clk);
        m_if.in_a = 16'h0040;
        m_if.in_b = 16'h0080;
        checks++;
        if (m_if.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full_ready got=%b exp=0", m_if.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_if.out_valid !== 1'b1 || {m_if.out_a, m_if.out_b} !== 64'h00000001_00000002) begin
                failures++;
                $display("FAIL bp_hold got=%b/%h exp=1/0000000100000002",
                         m_if.out_valid, {m_if.out_a, m_if.out_b});
            end
            @(negedge clk);
        end
        m_if.in_valid = 1'b0;
        m_if.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sb.size() == 0 || m_if.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_drain got=%b/%h exp=queued", m_if.out_valid,
                         {m_if.out_a, m_if.out_b});
            end else begin
                exp_v = sb.pop_front();
                if ({m_if.out_a, m_if.out_b} !== exp_v) begin
                    failures++;
                    $display("FAIL bp_drain got=%h exp=%h", {m_if.out_a, m_if.out_b}, exp_v);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (m_if.out_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_third_dropped got=%b/%0d exp=0/0", m_if.out_valid, sb.size());
        end
        checks++;
        if (m_if.xfer_count !== 16'd3) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=3", m_if.xfer_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_if.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            m_if.in_a = a;
            m_if.in_b = b;
            m_if.in_valid = 1'b1;
            checks++;
            if (m_if.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready i=%0d got=%b exp=1", i, m_if.in_ready);
            end
            if (i > 0) begin
                checks++;
                if (sb.size() == 0 || m_if.out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_data i=%0d got=%b exp=valid", i, m_if.out_valid);
                end else begin
                    exp_v = sb.pop_front();
                    if ({m_if.out_a, m_if.out_b} !== exp_v) begin
                        failures++;
                        $display("FAIL b2b_data i=%0d got=%h exp=%h", i,
                                 {m_if.out_a, m_if.out_b}, exp_v);
                    end
                end
            end
            sb.push_back(model(a, b, 1));
            @(negedge clk);
        end
        m_if.in_valid = 1'b0;
        checks++;
        if (sb.size() == 0 || m_if.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_last got=%b exp=1", m_if.out_valid);
        end else begin
            exp_v = sb.pop_front();
            if ({m_if.out_a, m_if.out_b} !== exp_v) begin
                failures++;
                $display("FAIL b2b_last got=%h exp=%h", {m_if.out_a, m_if.out_b}, exp_v);
            end
        end
        @(negedge clk);
        checks++;
        if (m_if.xfer_count !== 16'd20) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=20", m_if.xfer_count);
        end
    endtask

    task automatic test_reset_mid();
        m_if.out_ready = 1'b0;
        m_if.in_valid = 1'b1;
        m_if.in_a = 16'h0003;
        m_if.in_b = 16'h0005;
        @(negedge clk);
        m_if.in_a = 16'h0007;
        m_if.in_b = 16'h0009;
        @(negedge clk);
        m_if.in_valid = 1'b0;
        checks++;
        if (m_if.in_ready !== 1'b0 || m_if.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_full got=%b/%b exp=0/1", m_if.in_ready, m_if.out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmid_flags got=%b/%b exp=0/1", m_if.out_valid, m_if.in_ready);
        end
        checks++;
        if ({m_if.out_a, m_if.out_b} !== 64'h0 || m_if.xfer_count !== 16'h0) begin
            failures++;
            $display("FAIL rmid_clear got=%h/%h exp=0/0", {m_if.out_a, m_if.out_b},
                     m_if.xfer_count);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        m_if.in_valid = 1'b1;
        m_if.in_a = 16'h0001;
        m_if.in_b = 16'hffff;
        m_if.out_ready = 1'b1;
        sb.push_back(model(16'h0001, 16'hffff, 1));
        @(negedge clk);
        m_if.in_valid = 1'b0;
        checks++;
        if (sb.size() == 0 || m_if.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_first got=%b exp=1", m_if.out_valid);
        end else begin
            exp_v = sb.pop_front();
            if ({m_if.out_a, m_if.out_b} !== exp_v) begin
                failures++;
                $display("FAIL rmid_first got=%h exp=%h", {m_if.out_a, m_if.out_b}, exp_v);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        c_if.out_ready = 1'b1;
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < (round == 0 ? 15 : 2); i++) begin
                @(negedge clk);
                c_if.in_valid = 1'b1;
                c_if.in_a = 16'(i);
                c_if.in_b = 16'(i + 1);
            end
            @(negedge clk);
            c_if.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (c_if.xfer_count !== 4'hf) begin
                failures++;
                $display("FAIL sat_count round=%0d got=%h exp=f", round, c_if.xfer_count);
            end
        end
    endtask

    task automatic test_shift0();
        @(negedge clk);
        z_if.in_valid = 1'b1;
        z_if.in_a = 16'h8001;
        z_if.in_b = 16'hffff;
        z_if.out_ready = 1'b0;
        sb.push_back(model(16'h8001, 16'hffff, 0));
        @(negedge clk);
        z_if.in_valid = 1'b0;
        checks++;
        if (z_if.out_a !== 32'h00008001) begin
            failures++;
            $display("FAIL sh0_a got=%h exp=00008001", z_if.out_a);
        end
        checks++;
        if (sb.size() == 0 || z_if.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL sh0_pair got=%b exp=1", z_if.out_valid);
        end else begin
            exp_v = sb.pop_front();
            if ({z_if.out_a, z_if.out_b} !== exp_v) begin
                failures++;
                $display("FAIL sh0_pair got=%h exp=%h", {z_if.out_a, z_if.out_b}, exp_v);
            end
        end
        z_if.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (z_if.out_valid !== 1'b0 || z_if.xfer_count !== 16'd1) begin
            failures++;
            $display("FAIL sh0_done got=%b/%0d exp=0/1", z_if.out_valid, z_if.xfer_count);
        end
    endtask

    initial begin
        m_if.in_valid = 1'b0;
        m_if.in_a = '0;
        m_if.in_b = '0;
        m_if.out_ready = 1'b0;
        c_if.in_valid = 1'b0;
        c_if.in_a = '0;
        c_if.in_b = '0;
        c_if.out_ready = 1'b0;
        z_if.in_valid = 1'b0;
        z_if.in_a = '0;
        z_if.in_b = '0;
        z_if.out_ready = 1'b0;
        test_reset();
        test_first_pair();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        test_shift0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_operand_stage.md
Name: shift_operand_stage

Overview:
- Upstream operand-preparation stage for the 32x32 multiplier block.
- Accepts raw 16-bit operand pairs over a valid/ready handshake and applies the right-shift mask (logical shift right by SHIFT).
- Zero-extends each shifted operand to 32 bits and presents the pair to the multiplier through a registered 2-entry skid buffer.
- Keeps a saturating count of pairs delivered downstream.

Parameters:
- IN_W, 16, raw operand width.
- OUT_W, 32, delivered operand width. Must satisfy OUT_W >= IN_W; otherwise elaboration error.
- SHIFT, 1, logical right-shift amount applied to both operands. Legal range 0..IN_W-1; otherwise elaboration error.
- CNT_W, 16, width of the delivered-pair counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream pair valid.
- in_ready  output  1  stage can accept a pair.
- in_a  input  IN_W  raw operand A.
- in_b  input  IN_W  raw operand B.
- out_valid  output  1  shifted pair available.
- out_ready  input  1  multiplier side accepts the pair.
- out_a  output  OUT_W  zero-extended (in_a >> SHIFT).
- out_b  output  OUT_W  zero-extended (in_b >> SHIFT).
- xfer_count  output  CNT_W  number of out handshakes; saturates at all-ones.

Behaviour:
- Handshakes:
  - Input handshake occurs when in_valid && in_ready.
  - Output handshake occurs when out_valid && out_ready.
- Transform: shift each operand, then zero-extend; upper OUT_W-IN_W+SHIFT bits are 0. Performed on capture; registers hold post-shift values.
- Storage: main register (drives out_a/out_b) and skid register, each holding an {a,b} pair.
- States: EMPTY, ONE, TWO. out_valid = (state != EMPTY). in_ready = (state != TWO). Both decode directly from the state register, so no combinational in->out paths.
- EMPTY:
  - in hs -> load main; go to ONE.
  - Otherwise stay.
- ONE:
  - in hs && out hs -> load main with new pair; stay in ONE.
  - in hs only -> load skid; go to TWO.
  - out hs only -> go to EMPTY.
- TWO:
  - out hs -> main <= skid; go to ONE.
  - No input accepted (in_ready=0).
- Latency: pair accepted at edge N is visible on out_a/out_b with out_valid=1 after edge N (1 cycle) when the stage was EMPTY, or ONE with out hs.
- Ordering: strict FIFO; no pair is dropped or duplicated.
- Stability: while out_valid && !out_ready, out_a/out_b/out_valid hold their values across edges.
- Counter: xfer_count increments on each out hs. At all-ones it stays all-ones.
- Reset (asserted at any time, including mid-transfer):
  - Immediately forces state=EMPTY, out_valid=0, in_ready=1.
  - Clears out_a=0, out_b=0, skid=0, xfer_count=0.
  - In-flight pairs are discarded.
  - First accept is possible on the first edge after rst deasserts.
- in_a/in_b are ignored when !in_valid. Inputs presented while in_ready=0 are not captured.
- Embedded immediate assertions (disabled in reset):
  - !(out_valid && !in_ready && state==EMPTY).
  - Output stability under backpressure.
  - Upper bits of out_a/out_b are zero.

Decomposition:
- Package shift_operand_pkg holds:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t.
  - typedef struct packed {logic [OUT_W-1:0] a, b;} op_pair_t, using package constants OP_IN_W=16 and OP_OUT_W=32.
  - function shift_mask(IN_W value) returning the zero-extended OUT_W value.
- One sub-module is natural: skid_buffer2, a generic 2-entry valid/ready register slice parameterised on the payload type. Top = shift_mask on input + skid_buffer2 + counter.

Test Plan:
- Reset, then in_a=16'hfff0, in_b=16'h00e4, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_a=32'h00007ff8, out_b=32'h00000072 (downstream product 32'h0038fc70); xfer_count=1.
- Hold out_ready=0, push pairs {16'h0002,16'h0004} then {16'h0010,16'h0020} -> state TWO, in_ready=0, out_a=1/out_b=2 held stable; third pair not captured. Release out_ready -> out delivers 1/2, then 8/16, in order.
- Back-to-back stream of 20 pairs with out_ready=1 -> one pair per cycle, in_ready never drops, xfer_count=20.
- Assert rst while in TWO holding two pairs -> out_valid=0, in_ready=1, out_a=out_b=0, xfer_count=0 immediately. After release, a new pair {16'h0001,16'hffff} yields out_a=0, out_b=32'h00007fff.
- Preload xfer_count near saturation (CNT_W=4 build, 17 transfers) -> count reaches 4'hf and stays 4'hf.
- SHIFT=0 build: in_a=16'h8001 -> out_a=32'h00008001 (zero-extended, no sign extension).
